cmd_issuer: RTL and testbench

- Instruction-issue front end for processor_no_mem: the initiator side of its command/run/done interface.
- Buffers RV32I instruction words written by a host or loader, then issues them one at a time on command/run and waits for done before issuing the next.
- Counts retired instructions and flags a hung core with a watchdog timeout.
- Sits between a loader (future instruction memory or debug port) and the processor core.

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/issue_fifo.sv | 79 +++++++
 rtl/cmd_issuer.sv | 136 +++++++++++++
 tb/tb_cmd_issuer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction word type, opcode / funct constants
// and the canonical NOP (ADDI x0,x0,0) used as the idle command value.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] insn_t;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;

    // funct3 for OP / OP_IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 for OP
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // R-type field view of an instruction word
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rtype_t;

    // ADDI x0, x0, 0
    localparam insn_t RV_NOP = {12'd0, 5'd0, F3_ADD_SUB, 5'd0, OP_IMM};

    function automatic logic [6:0] opcode_of(input insn_t insn);
        rtype_t f;
        f = rtype_t'(insn);
        return f.opcode;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous instruction FIFO, DEPTH x 32.
// Ports: clk, reset (async active-high); push/push_data write side;
// pop/head_c read side (head_c is the combinational head word);
// flush empties the FIFO and wins over a same-cycle push;
// full/empty are registered occupancy flags.
module issue_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  insn_t push_data,
    input  logic  pop,
    input  logic  flush,
    output insn_t head_c,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    insn_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    // full is the pre-pop flag, so a push while full is dropped even on a pop cycle
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head_c  = mem[rd_ptr];

    // Next occupancy
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Pointers and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == CW'(0));
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cmd_issuer.sv
// Instruction-issue front end: buffers instruction words and issues them one
// at a time to the core over command/run, waiting for done in between.
// Ports: clk, reset (async active-high); wr_en/wr_data/full/empty loader side;
// start/clear_err control; command/run/done core handshake; busy, retired
// (wrapping count of completed instructions), overflow (sticky dropped write),
// timeout_err (watchdog expired, held until clear_err).
module cmd_issuer
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter insn_t       NOP     = RV_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        full,
    output logic        empty,
    input  logic        start,
    input  logic        clear_err,
    output logic [31:0] command,
    output logic        run,
    input  logic        done,
    output logic        busy,
    output logic [15:0] retired,
    output logic        overflow,
    output logic        timeout_err
);

    localparam int unsigned WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_ERR
    } state_t;

    state_t        state;
    logic [WW-1:0] watchdog;
    insn_t         head_c;
    logic          pop_c;
    logic          flush_c;
    logic          expired_c;

    assign expired_c = (watchdog == WW'(TIMEOUT - 1));
    assign pop_c     = (state == S_ISSUE) && !empty;
    // done on the expiry cycle wins, so the flush only fires on a real timeout
    assign flush_c   = (state == S_WAIT) && !done && expired_c;

    issue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_en),
        .push_data(wr_data),
        .pop      (pop_c),
        .flush    (flush_c),
        .head_c   (head_c),
        .full     (full),
        .empty    (empty)
    );

    // Issue FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            watchdog    <= '0;
            command     <= NOP;
            run         <= 1'b0;
            busy        <= 1'b0;
            retired     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wr_en && full) overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    if (empty) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        command  <= head_c;
                        watchdog <= '0;
                        run      <= 1'b1;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (done) begin
                        run     <= 1'b0;
                        retired <= retired + 16'd1;
                        state   <= S_GAP;
                    end else if (expired_c) begin
                        run         <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_ERR;
                    end else begin
                        watchdog <= watchdog + WW'(1);
                    end
                end

                S_GAP: begin
                    state <= S_ISSUE;
                end

                S_ERR: begin
                    if (clear_err) begin
                        timeout_err <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    run   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: transaction-level reference model,
// per-cycle compare, directed scenarios plus a randomized phase.
module tb_cmd_issuer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        empty;
    logic        start;
    logic        clear_err;
    logic [31:0] command;
    logic        run;
    logic        done;
    logic        done_core;
    logic        done_stim;
    logic        busy;
    logic [15:0] retired;
    logic        overflow;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    assign done = done_core | done_stim;

    cmd_issuer #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .NOP    (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .start      (start),
        .clear_err  (clear_err),
        .command    (command),
        .run        (run),
        .done       (done),
        .busy       (busy),
        .retired    (retired),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Instruction in flight, countdown (in edges) to the next issue attempt,
    // and an error flag; the FIFO is a plain queue.
    logic [31:0] q[$];
    int          pending;
    bit          m_run;
    bit          m_err;
    int          m_wait;
    logic [15:0] m_ret;
    logic [31:0] m_cmd;
    bit          m_ovf;
    bit          m_was_full;
    bit          m_flush;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            pending = 0;
            m_run   = 0;
            m_err   = 0;
            m_wait  = 0;
            m_ret   = '0;
            m_cmd   = NOP;
            m_ovf   = 0;
        end else begin
            m_was_full = (q.size() == DEPTH);
            m_flush    = 0;
            if (wr_en && m_was_full) m_ovf = 1;
            if (m_err) begin
                if (clear_err) m_err = 0;
            end else if (m_run) begin
                if (done) begin
                    // instruction retires; next issue attempt two edges later
                    m_run   = 0;
                    m_ret   = m_ret + 16'd1;
                    pending = 2;
                end else if (m_wait == TIMEOUT - 1) begin
                    m_run   = 0;
                    m_err   = 1;
                    m_flush = 1;
                end else begin
                    m_wait++;
                end
            end else if (pending > 0) begin
                pending--;
                if (pending == 0 && q.size() > 0) begin
                    m_cmd  = q.pop_front();
                    m_run  = 1;
                    m_wait = 0;
                end
            end else if (start) begin
                pending = 1;
            end
            if (m_flush) q.delete();
            else if (wr_en && !m_was_full) q.push_back(wr_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("cmp_run",         run,         32'(m_run));
            chk("cmp_command",     command,     m_cmd);
            chk("cmp_busy",        busy,        32'((pending > 0) || m_run));
            chk("cmp_retired",     retired,     32'(m_ret));
            chk("cmp_overflow",    overflow,    32'(m_ovf));
            chk("cmp_timeout_err", timeout_err, 32'(m_err));
            chk("cmp_empty",       empty,       32'(q.size() == 0));
            chk("cmp_full",        full,        32'(q.size() == DEPTH));
        end
    end

    // ---------------- core responder ----------------
    // mode 0: never done; 1: done after fixed_lat cycles of run; 2: random latency
    int core_mode = 0;
    int fixed_lat = 3;
    int cur_lat   = 3;
    int run_cnt   = 0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            done_core = 1'b0;
            run_cnt   = 0;
        end else begin
            if (run) run_cnt++;
            else run_cnt = 0;
            if (!run) begin
                if (core_mode == 2) cur_lat = ($urandom_range(0, 15) == 0) ? 80 : int'($urandom_range(1, 8));
                else cur_lat = fixed_lat;
            end
            done_core = (run && core_mode != 0 && run_cnt == cur_lat);
        end
    end

    // ---------------- issue monitor ----------------
    logic [31:0] issued[$];
    int          gaps[$];
    int          low_cnt  = 0;
    bit          seen_run = 0;
    bit          run_q    = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (run && !run_q) begin
                issued.push_back(command);
                if (seen_run) gaps.push_back(low_cnt);
            end
            if (run) begin
                low_cnt  = 0;
                seen_run = 1;
            end else begin
                low_cnt++;
            end
            run_q = run;
        end
    end

    // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
    task automatic write_word(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(name, busy, 0);
    endtask

    task automatic wait_run(input logic val, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            if (run === val) break;
            @(negedge clk);
        end
        chk(name, run, 32'(val));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [31:0] basic_w[3];
        logic [31:0] ow[17];
        int          base;
        int          gsz;
        int          hi_cnt;

        basic_w[0] = 32'h00A0_0093;
        basic_w[1] = 32'hFFC0_0113;
        basic_w[2] = 32'h0020_81B3;

        reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        clear_err = 1'b0; done_stim = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1;

        // reset values
        chk("rst_command", command, NOP);
        chk("rst_run", run, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_retired", retired, 0);

        // basic issue with done 3 cycles after run rises
        core_mode = 1; fixed_lat = 3;
        base = issued.size();
        for (int i = 0; i < 3; i++) write_word(basic_w[i]);
        pulse_start();
        chk("lat_k1_run_low", run, 0);
        @(negedge clk);
        chk("lat_k2_run_high", run, 1);
        chk("lat_k2_command", command, basic_w[0]);
        wait_idle(100, "basic_idle");
        chk("basic_retired", retired, 3);
        chk("basic_model_retired", m_ret, 3);
        chk("basic_issued_cnt", issued.size() - base, 3);
        for (int i = 0; i < 3; i++) chk("basic_order", issued[base + i], basic_w[i]);
        gsz = gaps.size();
        chk("basic_gap_cnt", gsz, 2);
        chk("basic_gap0", gaps[gsz - 2], 2);
        chk("basic_gap1", gaps[gsz - 1], 2);

        // overflow: 17 writes into a 16-entry FIFO
        fixed_lat = 2;
        base = issued.size();
        for (int i = 0; i < 17; i++) ow[i] = $urandom;
        for (int i = 0; i < 16; i++) write_word(ow[i]);
        chk("ovf_full_at_16", full, 1);
        chk("ovf_not_yet", overflow, 0);
        write_word(ow[16]);
        chk("ovf_set", overflow, 1);
        chk("ovf_still_full", full, 1);
        pulse_start();
        wait_idle(400, "ovf_idle");
        chk("ovf_retired", retired, 19);
        chk("ovf_issued_cnt", issued.size() - base, 16);
        chk("ovf_first", issued[base], ow[0]);
        chk("ovf_last", issued[base + 15], ow[15]);

        // timeout: core never answers
        core_mode = 0;
        write_word(32'h0010_0093);
        write_word(32'h0020_0113);
        pulse_start();
        hi_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (run) hi_cnt++;
            if (timeout_err) break;
        end
        chk("to_wait_cycles", hi_cnt, TIMEOUT);
        chk("to_err", timeout_err, 1);
        chk("to_run_low", run, 0);
        chk("to_flushed", empty, 1);
        chk("to_busy_low", busy, 0);
        write_word(32'h0030_0193);
        chk("to_write_in_err", empty, 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("to_cleared", timeout_err, 0);
        chk("to_retired_same", retired, 19);

        // stray done in IDLE and GAP
        done_stim = 1'b1;
        @(negedge clk);
        done_stim = 1'b0;
        chk("stray_idle_retired", retired, 19);
        core_mode = 1; fixed_lat = 1;
        write_word(32'h0040_0213);
        write_word(32'h0050_0293);
        pulse_start();
        wait_run(1'b1, 20, "stray_run_up");
        @(negedge clk);
        wait_run(1'b0, 20, "stray_run_down");
        done_stim = 1'b1;
        @(negedge clk);
        done_stim = 1'b0;
        wait_idle(100, "stray_idle");
        chk("stray_retired", retired, 22);

        // done on the same cycle the watchdog expires
        fixed_lat = TIMEOUT;
        write_word(32'h0060_0313);
        pulse_start();
        wait_idle(200, "sim_idle");
        chk("sim_no_err", timeout_err, 0);
        chk("sim_retired", retired, 23);

        // randomized phase
        core_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_data   = $urandom;
            start     = ($urandom_range(0, 7) == 0);
            done_stim = ($urandom_range(0, 19) == 0);
            clear_err = timeout_err && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0; done_stim = 1'b0; clear_err = 1'b0;
        wait_idle(300, "rand_drain");
        if (timeout_err) begin
            clear_err = 1'b1;
            @(negedge clk);
            clear_err = 1'b0;
        end

        // reset mid-WAIT: outputs clear without a clock edge
        core_mode = 0;
        write_word(32'h0070_0393);
        pulse_start();
        wait_run(1'b1, 40, "rst_setup_run");
        chk("pre_rst_overflow", overflow, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_run", run, 0);
        chk("mid_rst_command", command, NOP);
        chk("mid_rst_retired", retired, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
